// File: rtl/parity_pkg.sv
// parity_pkg: definitions shared by the parity generator and checker.
//   link_state_t  - link-health FSM encoding exposed on link_state.
//   PARITY_EVEN / PARITY_ODD - parity sense selectors.
//   DEFAULT_WIDTH - data word width used by both ends of the link.
package parity_pkg;

    typedef enum logic [1:0] {
        GOOD    = 2'd0,
        SUSPECT = 2'd1,
        ALARM   = 2'd2
    } link_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/parity_err_monitor.sv
// parity_err_monitor: link-health status for the receive datapath.
// Sits at the output stage of parity_checker. Its registers update on the
// same edge as the output stage, so the status always describes the word
// currently presented on data_out.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   word_valid_i    - a word is being loaded into the output stage
//   word_err_i      - that word has a parity mismatch
//   err_clr_i       - clears sticky flag, counter and FSM (wins over errors)
//   err_sticky_o    - any error seen since the last clear
//   err_count_o     - saturating count of erroneous words
//   alarm_o         - FSM is in ALARM
//   link_state_o    - FSM state encoding
module parity_err_monitor
    import parity_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_valid_i,
    input  logic             word_err_i,
    input  logic             err_clr_i,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic             alarm_o,
    output logic [1:0]       link_state_o
);

    localparam logic [7:0] THRESH = 8'(ALARM_THRESH);

    link_state_t      state_q, state_d;
    logic [7:0]       consec_q, consec_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= GOOD;
            consec_q <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        sticky_d = sticky_q;
        count_d  = count_q;

        if (err_clr_i) begin
            // Clear wins: a coincident error is reported on parity_err only.
            state_d  = GOOD;
            consec_d = '0;
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (word_valid_i) begin
            if (word_err_i) begin
                sticky_d = 1'b1;
                if (count_q != '1) count_d = count_q + CNT_W'(1);
            end

            unique case (state_q)
                GOOD: begin
                    if (word_err_i) begin
                        consec_d = 8'd1;
                        state_d  = (THRESH == 8'd1) ? ALARM : SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (word_err_i) begin
                        consec_d = consec_q + 8'd1;
                        if (consec_q + 8'd1 == THRESH) state_d = ALARM;
                    end else begin
                        consec_d = '0;
                        state_d  = GOOD;
                    end
                end
                ALARM: begin
                    // Absorbing: only err_clr or rst leaves.
                end
                default: begin
                    state_d  = GOOD;
                    consec_d = '0;
                end
            endcase
        end
    end

    assign err_sticky_o = sticky_q;
    assign err_count_o  = count_q;
    assign alarm_o      = (state_q == ALARM);
    assign link_state_o = state_q;

endmodule

// File: rtl/parity_checker.sv
// parity_checker: receive-side parity check for a streaming word.
// Two-stage pipeline: stage 1 captures the word and its parity bit, stage 2
// presents the word with its mismatch flag. Latency is exactly 2 cycles,
// one word per cycle, no backpressure. Link-health status is kept by
// parity_err_monitor, updated together with stage 2.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - data_in/parity_in qualify this cycle
//   data_in    - received word
//   parity_in  - received parity bit
//   err_clr    - clear pulse for the link-health status
//   out_valid  - data_out/parity_err qualify this cycle
//   data_out   - data_in delayed 2 cycles (holds across bubbles)
//   parity_err - mismatch for the word on data_out
//   err_sticky, err_count, alarm, link_state - link-health status
module parity_checker
    import parity_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 4,
    parameter int ODD          = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             parity_in,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             parity_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic             alarm,
    output logic [1:0]       link_state
);

    localparam logic SENSE = (ODD != 0) ? PARITY_ODD : PARITY_EVEN;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_parity_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_err_q;
    logic             s1_err;

    // Mismatch is qualified by valid so bubbles never raise parity_err.
    assign s1_err = s1_valid_q & (^s1_data_q ^ s1_parity_q ^ SENSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_parity_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_err_q    <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q   <= data_in;
                s1_parity_q <= parity_in;
            end
            s2_valid_q <= s1_valid_q;
            s2_err_q   <= s1_err;
            // data_out keeps the last valid word across bubbles.
            if (s1_valid_q) s2_data_q <= s1_data_q;
        end
    end

    parity_err_monitor #(
        .CNT_W        (CNT_W),
        .ALARM_THRESH (ALARM_THRESH)
    ) u_mon (
        .clk          (clk),
        .rst          (rst),
        .word_valid_i (s1_valid_q),
        .word_err_i   (s1_err),
        .err_clr_i    (err_clr),
        .err_sticky_o (err_sticky),
        .err_count_o  (err_count),
        .alarm_o      (alarm),
        .link_state_o (link_state)
    );

    assign out_valid  = s2_valid_q;
    assign data_out   = s2_data_q;
    assign parity_err = s2_err_q;

endmodule

// File: tb/tb_parity_checker.sv
// Directed, table-driven bench for parity_checker. Three instances:
//   u0: defaults (even parity, CNT_W=16, threshold 4)
//   u1: CNT_W=2, ALARM_THRESH=1 (counter saturation, immediate alarm)
//   u2: ODD=1
// Each table row drives one instance for one cycle and lists the outputs
// expected just after that clock edge.
module tb_parity_checker;
    import parity_pkg::*;

    localparam logic [31:0] FE = 32'hFFFF_FFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv  [3];
    logic [31:0] di  [3];
    logic        pi  [3];
    logic        clr [3];
    logic        ov  [3];
    logic [31:0] dout[3];
    logic        pe  [3];
    logic        st  [3];
    logic        al  [3];
    logic [1:0]  ls  [3];
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt1;

    parity_checker u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .data_in(di[0]), .parity_in(pi[0]),
        .err_clr(clr[0]), .out_valid(ov[0]), .data_out(dout[0]), .parity_err(pe[0]),
        .err_sticky(st[0]), .err_count(cnt0), .alarm(al[0]), .link_state(ls[0]));

    parity_checker #(.CNT_W(2), .ALARM_THRESH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .data_in(di[1]), .parity_in(pi[1]),
        .err_clr(clr[1]), .out_valid(ov[1]), .data_out(dout[1]), .parity_err(pe[1]),
        .err_sticky(st[1]), .err_count(cnt1), .alarm(al[1]), .link_state(ls[1]));

    parity_checker #(.ODD(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .data_in(di[2]), .parity_in(pi[2]),
        .err_clr(clr[2]), .out_valid(ov[2]), .data_out(dout[2]), .parity_err(pe[2]),
        .err_sticky(st[2]), .err_count(cnt2), .alarm(al[2]), .link_state(ls[2]));

    typedef struct {
        int          dut;
        logic        v;
        logic [31:0] d;
        logic        p;
        logic        c;
        logic        eov;
        logic [31:0] edo;
        logic        epe;
        logic        est;
        logic [15:0] ecnt;
        logic        eal;
        logic [1:0]  els;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic vec_t mk(int dut, logic v, logic [31:0] d, logic p, logic c,
                                logic eov, logic [31:0] edo, logic epe, logic est,
                                logic [15:0] ecnt, logic eal, logic [1:0] els);
        vec_t r;
        r.dut = dut; r.v = v; r.d = d; r.p = p; r.c = c;
        r.eov = eov; r.edo = edo; r.epe = epe; r.est = est;
        r.ecnt = ecnt; r.eal = eal; r.els = els;
        return r;
    endfunction

    function automatic logic [15:0] cnt_of(int k);
        case (k)
            0:       return cnt0;
            1:       return {14'd0, cnt1};
            default: return cnt2;
        endcase
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk(int k, string tag, logic eov, logic [31:0] edo, logic epe,
                       logic est, logic [15:0] ecnt, logic eal, logic [1:0] els);
        cmp({tag, ".out_valid"},  32'(ov[k]),    32'(eov));
        cmp({tag, ".data_out"},   dout[k],       edo);
        cmp({tag, ".parity_err"}, 32'(pe[k]),    32'(epe));
        cmp({tag, ".err_sticky"}, 32'(st[k]),    32'(est));
        cmp({tag, ".err_count"},  32'(cnt_of(k)), 32'(ecnt));
        cmp({tag, ".alarm"},      32'(al[k]),    32'(eal));
        cmp({tag, ".link_state"}, 32'(ls[k]),    32'(els));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; di[k] = '0; pi[k] = 1'b0; clr[k] = 1'b0;
        end

        // u0: basic good/bad words, recovery, then 4 bad words -> ALARM
        tbl.push_back(mk(0, 1, 32'h1, 1, 0,  0, 32'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0,  1, 32'h1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h1, 0, 0,  0, 32'h1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3, 0, 0,  1, 32'h1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0,  1, 32'h3, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 1,  0, 32'h3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, FE,    0, 0,  0, 32'h3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, FE,    0, 0,  1, FE,    1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0,  1, FE,    1, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0,  0, FE,    0, 1, 2, 0, 1));
        tbl.push_back(mk(0, 1, FE,    0, 0,  0, FE,    0, 1, 2, 0, 1));
        tbl.push_back(mk(0, 1, FE,    0, 0,  1, FE,    1, 1, 3, 0, 1));
        tbl.push_back(mk(0, 1, 32'h3, 0, 0,  1, FE,    1, 1, 4, 1, 2));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0,  1, 32'h3, 0, 1, 4, 1, 2));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0,  0, 32'h3, 0, 1, 4, 1, 2));
        // u1: counter saturates at 3, alarm after first error, clear on 5th
        tbl.push_back(mk(1, 1, FE,    0, 0,  0, 32'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, FE,    0, 0,  1, FE,    1, 1, 1, 1, 2));
        tbl.push_back(mk(1, 1, FE,    0, 0,  1, FE,    1, 1, 2, 1, 2));
        tbl.push_back(mk(1, 1, FE,    0, 0,  1, FE,    1, 1, 3, 1, 2));
        tbl.push_back(mk(1, 1, FE,    0, 0,  1, FE,    1, 1, 3, 1, 2));
        tbl.push_back(mk(1, 0, 32'h0, 0, 1,  1, FE,    1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0, 0, 0,  0, FE,    0, 0, 0, 0, 0));
        // u2: odd parity sense
        tbl.push_back(mk(2, 1, 32'h0, 1, 0,  0, 32'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 1, 32'h0, 0, 0,  1, 32'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 1, 32'h1, 0, 0,  1, 32'h0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(2, 0, 32'h0, 0, 0,  1, 32'h1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(2, 0, 32'h0, 0, 0,  0, 32'h1, 0, 1, 1, 0, 0));

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) chk(k, $sformatf("reset.u%0d", k), 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            iv[tbl[i].dut]  = tbl[i].v;
            di[tbl[i].dut]  = tbl[i].d;
            pi[tbl[i].dut]  = tbl[i].p;
            clr[tbl[i].dut] = tbl[i].c;
            step();
            iv[tbl[i].dut]  = 1'b0;
            clr[tbl[i].dut] = 1'b0;
            chk(tbl[i].dut, $sformatf("row%0d.u%0d", i, tbl[i].dut), tbl[i].eov, tbl[i].edo,
                tbl[i].epe, tbl[i].est, tbl[i].ecnt, tbl[i].eal, tbl[i].els);
        end

        // Reset with two valid words in flight on u0 (which sits in ALARM).
        iv[0] = 1'b1; di[0] = 32'hA; pi[0] = 1'b0;
        step();
        di[0] = 32'h5; pi[0] = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; iv[0] = 1'b0;
        chk(0, "rst_mid.edge", 0, 0, 0, 0, 0, 0, 0);
        chk(2, "rst_mid.u2",   0, 0, 0, 0, 0, 0, 0);
        step();
        chk(0, "rst_mid.flush", 0, 0, 0, 0, 0, 0, 0);
        iv[0] = 1'b1; di[0] = 32'h6; pi[0] = 1'b0;
        step();
        iv[0] = 1'b0;
        chk(0, "post_rst.lat1", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk(0, "post_rst.lat2", 1, 32'h6, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
